lcd_pattern_gen: RTL

- Parametrised test-pattern generator for the TFT LCD path. Sits between the LCD timing block (pixel coordinates, data enable, frame pulse) and the lcd_r/g/b pins.
- Replaces the fixed checkerboard and moving red tile with a selectable pattern mode, parametrised geometry, tile size, colour widths and cursor step rate.
- Provides a frame-locked mode shadow and a pause control.

---
 rtl/lcd_pattern_gen.sv | 181 ++++++++++++++++++
 1 files changed

// File: rtl/lcd_pattern_gen.sv
// Test-pattern generator for the TFT LCD path: frame-locked mode shadow, stepping cursor tile, 2-cycle colour pipe.
// Optional PATTERN_BORDER_EN macro forces white on the active-area border pixels.
module lcd_pattern_gen #(
  parameter int unsigned H_ACTIVE    = 480,
  parameter int unsigned V_ACTIVE    = 272,
  parameter int unsigned COORD_W     = 10,
  parameter int unsigned TILE_LOG2   = 3,
  parameter int unsigned R_W         = 5,
  parameter int unsigned G_W         = 6,
  parameter int unsigned B_W         = 5,
  parameter int unsigned GRAD_SHIFT  = 4,
  parameter int unsigned BAR_SHIFT   = 6,
  parameter int unsigned STEP_FRAMES = 1
) (
  input  logic               in_clk,
  input  logic               in_rst_n,
  input  logic [COORD_W-1:0] in_pixelx,
  input  logic [COORD_W-1:0] in_pixely,
  input  logic               in_de,
  input  logic               in_frame_start,
  input  logic [1:0]         in_mode,
  input  logic               in_pause,
  output logic [R_W-1:0]     out_r,
  output logic [G_W-1:0]     out_g,
  output logic [B_W-1:0]     out_b,
  output logic               out_de,
  output logic [6:0]         out_tilex,
  output logic [6:0]         out_tiley,
  output logic [15:0]        out_frame_cnt
);

  localparam int unsigned TILE   = 1 << TILE_LOG2;
  localparam int unsigned NX     = (H_ACTIVE + TILE - 1) / TILE;
  localparam int unsigned NY     = (V_ACTIVE + TILE - 1) / TILE;
  localparam int unsigned STEP_W = (STEP_FRAMES > 1) ? $clog2(STEP_FRAMES) : 1;

  localparam logic [R_W-1:0] R_HALF = {1'b0, {(R_W-1){1'b1}}};
  localparam logic [G_W-1:0] G_HALF = {1'b0, {(G_W-1){1'b1}}};
  localparam logic [B_W-1:0] B_HALF = {1'b0, {(B_W-1){1'b1}}};

  logic [STEP_W-1:0]  step_cnt;
  logic [1:0]         mode_sh;
  logic [6:0]         tilex_nxt;
  logic [6:0]         tiley_nxt;
  logic               hit_c;

  logic [COORD_W-1:0] x1;
  logic [2:0]         y1_chk;
  logic               de1;
  logic               hit1;
  logic [1:0]         mode1;
  logic [R_W-1:0]     r_c;
  logic [G_W-1:0]     g_c;
  logic [B_W-1:0]     b_c;
  logic [2:0]         bar_idx;

`ifdef PATTERN_BORDER_EN
  logic               border_c;
  logic               border1;
  assign border_c = (in_pixelx == COORD_W'(0)) || (in_pixelx == COORD_W'(H_ACTIVE - 1)) ||
                    (in_pixely == COORD_W'(0)) || (in_pixely == COORD_W'(V_ACTIVE - 1));
`endif

  // Raster-order successor of the current cursor tile
  always_comb begin
    tilex_nxt = out_tilex + 7'd1;
    tiley_nxt = out_tiley;
    if (out_tilex == 7'(NX - 1)) begin
      tilex_nxt = 7'd0;
      tiley_nxt = (out_tiley == 7'(NY - 1)) ? 7'd0 : out_tiley + 7'd1;
    end
  end

  // Frame-rate state: frame counter, mode shadow, step divider and cursor
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_frame_cnt <= '0;
      mode_sh       <= '0;
      step_cnt      <= '0;
      out_tilex     <= '0;
      out_tiley     <= '0;
    end else if (in_frame_start) begin
      out_frame_cnt <= out_frame_cnt + 16'd1;
      mode_sh       <= in_mode;
      if (!in_pause) begin
        if (step_cnt == STEP_W'(STEP_FRAMES - 1)) begin
          step_cnt  <= '0;
          out_tilex <= tilex_nxt;
          out_tiley <= tiley_nxt;
        end else begin
          step_cnt  <= step_cnt + STEP_W'(1);
        end
      end
    end
  end

  assign hit_c = ((in_pixelx >> TILE_LOG2) == COORD_W'(out_tilex)) &&
                 ((in_pixely >> TILE_LOG2) == COORD_W'(out_tiley));

  // Stage 1: coordinates, de, cursor hit and the mode in force when the pixel entered
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      x1      <= '0;
      y1_chk  <= '0;
      de1     <= 1'b0;
      hit1    <= 1'b0;
      mode1   <= '0;
`ifdef PATTERN_BORDER_EN
      border1 <= 1'b0;
`endif
    end else begin
      x1      <= in_pixelx;
      y1_chk  <= in_pixely[TILE_LOG2 +: 3];
      de1     <= in_de;
      hit1    <= hit_c;
      mode1   <= mode_sh;
`ifdef PATTERN_BORDER_EN
      border1 <= border_c;
`endif
    end
  end

  assign bar_idx = 3'(x1 >> BAR_SHIFT);

  // Colour select; priority border > cursor > mode
  always_comb begin
    r_c = '0;
    g_c = '0;
    b_c = '0;
    if (!de1) begin
      r_c = '0;
`ifdef PATTERN_BORDER_EN
    end else if (border1) begin
      r_c = '1;
      g_c = '1;
      b_c = '1;
`endif
    end else if (hit1) begin
      r_c = '1;
    end else begin
      case (mode1)
        2'd0: begin
          r_c = (x1[TILE_LOG2]     ^ y1_chk[0]) ? R_HALF : '0;
          g_c = (x1[TILE_LOG2 + 1] ^ y1_chk[1]) ? G_HALF : '0;
          b_c = (x1[TILE_LOG2 + 2] ^ y1_chk[2]) ? B_HALF : '0;
        end
        2'd1: begin
          r_c = R_W'(x1 >> GRAD_SHIFT);
          g_c = G_W'(x1 >> GRAD_SHIFT);
          b_c = B_W'(x1 >> GRAD_SHIFT);
        end
        2'd2: begin
          r_c = bar_idx[2] ? '1 : '0;
          g_c = bar_idx[1] ? '1 : '0;
          b_c = bar_idx[0] ? '1 : '0;
        end
        default: begin
          r_c = '1;
          g_c = '1;
          b_c = '1;
        end
      endcase
    end
  end

  // Stage 2: registered colour and aligned de
  always_ff @(posedge in_clk or negedge in_rst_n) begin
    if (!in_rst_n) begin
      out_r  <= '0;
      out_g  <= '0;
      out_b  <= '0;
      out_de <= 1'b0;
    end else begin
      out_r  <= r_c;
      out_g  <= g_c;
      out_b  <= b_c;
      out_de <= de1;
    end
  end

endmodule
